// File: rtl/time_entry_receiver.sv
// Keypad time-entry receiver for the microwave controller.
// Shifts BCD digits into a min:sec_tens:sec_ones register as keys are
// pressed, validates the entry on commit and hands it to the timer with
// a valid/ready handshake. Digit strobes are edge-detected so a long key
// press counts once.
module time_entry_receiver (
  input  logic       clock,
  input  logic       clearn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       busy,
  input  logic       commit,
  input  logic       cancel,
  input  logic       xfer_ready,
  output logic [3:0] min,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] digit_count,
  output logic       xfer_valid,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2,
    XFER  = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] min_reg, min_next;
  logic [3:0] sec_tens_reg, sec_tens_next;
  logic [3:0] sec_ones_reg, sec_ones_next;
  logic [1:0] count_reg, count_next;
  logic       err_reg, err_next;
  logic       loadn_q_reg;
  // armed_reg stays low after reset until loadn has been seen high, so a
  // key already held down while reset was released is not taken as a press.
  logic       armed_reg;
  logic       digit_event;

  assign digit_event = ~loadn & loadn_q_reg & armed_reg;

  // Strobe history: registered loadn plus the post-reset arming flag.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      loadn_q_reg <= 1'b1;
      armed_reg   <= 1'b0;
    end else begin
      loadn_q_reg <= loadn;
      armed_reg   <= armed_reg | loadn;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state_reg    <= IDLE;
      min_reg      <= 4'd0;
      sec_tens_reg <= 4'd0;
      sec_ones_reg <= 4'd0;
      count_reg    <= 2'd0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      min_reg      <= min_next;
      sec_tens_reg <= sec_tens_next;
      sec_ones_reg <= sec_ones_next;
      count_reg    <= count_next;
      err_reg      <= err_next;
    end
  end

  // Next-state logic: cancel wins over everything, then the handshake in
  // XFER, then a digit event, and only then a commit (a commit arriving
  // with a digit is dropped). busy silences digits and commits only.
  always_comb begin
    state_next    = state_reg;
    min_next      = min_reg;
    sec_tens_next = sec_tens_reg;
    sec_ones_next = sec_ones_reg;
    count_next    = count_reg;
    err_next      = 1'b0;

    if (cancel) begin
      state_next    = IDLE;
      min_next      = 4'd0;
      sec_tens_next = 4'd0;
      sec_ones_next = 4'd0;
      count_next    = 2'd0;
    end else if (state_reg == XFER) begin
      if (xfer_ready) begin
        state_next    = IDLE;
        min_next      = 4'd0;
        sec_tens_next = 4'd0;
        sec_ones_next = 4'd0;
        count_next    = 2'd0;
      end
    end else if (!busy) begin
      if (digit_event) begin
        if (D > 4'd9 || state_reg == FULL) begin
          // Non-BCD key or no room left: flag it, keep the entry as is.
          err_next = 1'b1;
        end else begin
          sec_ones_next = D;
          sec_tens_next = sec_ones_reg;
          min_next      = sec_tens_reg;
          count_next    = count_reg + 2'd1;
          state_next    = (count_reg == 2'd2) ? FULL : ENTRY;
        end
      end else if (commit && state_reg != IDLE) begin
        if (sec_tens_reg > 4'd5) begin
          err_next = 1'b1;
        end else begin
          state_next = XFER;
        end
      end
    end
  end

  assign min         = min_reg;
  assign sec_tens    = sec_tens_reg;
  assign sec_ones    = sec_ones_reg;
  assign digit_count = count_reg;
  assign xfer_valid  = (state_reg == XFER);
  assign err         = err_reg;

endmodule

// File: tb/tb_time_entry_receiver.sv
// Directed testbench for time_entry_receiver. Inputs change 1 ns after the
// rising edge and outputs are sampled there too, away from the edge.
module tb_time_entry_receiver;

  logic       clock = 1'b0;
  logic       clearn;
  logic [3:0] D;
  logic       loadn;
  logic       busy;
  logic       commit;
  logic       cancel;
  logic       xfer_ready;
  logic [3:0] min, sec_tens, sec_ones;
  logic [1:0] digit_count;
  logic       xfer_valid;
  logic       err;

  int vectors = 0;
  int miscompares = 0;

  // {min, sec_tens, sec_ones, digit_count, xfer_valid, err}
  logic [15:0] obs;
  assign obs = {min, sec_tens, sec_ones, digit_count, xfer_valid, err};

  logic err_first, err_second;

  time_entry_receiver dut (
    .clock      (clock),
    .clearn     (clearn),
    .D          (D),
    .loadn      (loadn),
    .busy       (busy),
    .commit     (commit),
    .cancel     (cancel),
    .xfer_ready (xfer_ready),
    .min        (min),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .digit_count(digit_count),
    .xfer_valid (xfer_valid),
    .err        (err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One key press: loadn low three cycles then high one cycle. Records err
  // after the first and second edges of the press.
  task automatic press(input logic [3:0] d);
    D = d;
    loadn = 1'b0;
    tick();
    err_first = err;
    tick();
    err_second = err;
    tick();
    loadn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clearn = 1'b0; loadn = 1'b0; D = 4'd5; busy = 1'b0;
    commit = 1'b0; cancel = 1'b0; xfer_ready = 1'b0;
    #3;
    vectors++;
    if (obs !== 16'h0000) begin
      $display("FAIL reset_async obs=%h expected=%h", obs, 16'h0000); miscompares++;
    end
    tick(); tick();
    clearn = 1'b1;
    tick(); tick();
    vectors++;
    if (obs !== 16'h0000) begin
      $display("FAIL reset_held_loadn obs=%h expected=%h", obs, 16'h0000); miscompares++;
    end
    loadn = 1'b1;
    tick(); tick();
  endtask

  task automatic test_entry();
    logic [15:0] exp [3];
    exp[0] = {4'd0, 4'd0, 4'd1, 2'd1, 1'b0, 1'b0};
    exp[1] = {4'd0, 4'd1, 4'd3, 2'd2, 1'b0, 1'b0};
    exp[2] = {4'd1, 4'd3, 4'd0, 2'd3, 1'b0, 1'b0};
    press(4'd1);
    vectors++;
    if (obs !== exp[0]) begin
      $display("FAIL entry_key1 obs=%h expected=%h", obs, exp[0]); miscompares++;
    end
    press(4'd3);
    vectors++;
    if (obs !== exp[1]) begin
      $display("FAIL entry_key3 obs=%h expected=%h", obs, exp[1]); miscompares++;
    end
    press(4'd0);
    vectors++;
    if (obs !== exp[2]) begin
      $display("FAIL entry_key0 obs=%h expected=%h", obs, exp[2]); miscompares++;
    end
  endtask

  task automatic test_full_reject();
    press(4'd7);
    vectors++;
    if ({err_first, err_second} !== 2'b10) begin
      $display("FAIL full_err_pulse obs=%b expected=%b", {err_first, err_second}, 2'b10); miscompares++;
    end
    vectors++;
    if (obs !== {4'd1, 4'd3, 4'd0, 2'd3, 1'b0, 1'b0}) begin
      $display("FAIL full_hold obs=%h expected=%h", obs, {4'd1, 4'd3, 4'd0, 2'd3, 1'b0, 1'b0}); miscompares++;
    end
  endtask

  task automatic test_xfer();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    vectors++;
    if (obs !== {4'd1, 4'd3, 4'd0, 2'd3, 1'b1, 1'b0}) begin
      $display("FAIL xfer_start obs=%h expected=%h", obs, {4'd1, 4'd3, 4'd0, 2'd3, 1'b1, 1'b0}); miscompares++;
    end
    // A key during the transfer is ignored silently.
    press(4'd9);
    vectors++;
    if ({err_first, err_second} !== 2'b00 || obs !== {4'd1, 4'd3, 4'd0, 2'd3, 1'b1, 1'b0}) begin
      $display("FAIL xfer_key_ignored obs=%h err=%b expected=%h err=00", obs, {err_first, err_second},
               {4'd1, 4'd3, 4'd0, 2'd3, 1'b1, 1'b0}); miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (obs !== {4'd1, 4'd3, 4'd0, 2'd3, 1'b1, 1'b0}) begin
        $display("FAIL xfer_wait%0d obs=%h expected=%h", i, obs, {4'd1, 4'd3, 4'd0, 2'd3, 1'b1, 1'b0}); miscompares++;
      end
    end
    xfer_ready = 1'b1;
    tick();
    xfer_ready = 1'b0;
    vectors++;
    if (obs !== 16'h0000) begin
      $display("FAIL xfer_done obs=%h expected=%h", obs, 16'h0000); miscompares++;
    end
  endtask

  task automatic test_bad_commit();
    press(4'd7);
    press(4'd5);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    vectors++;
    if (obs !== {4'd0, 4'd7, 4'd5, 2'd2, 1'b0, 1'b1}) begin
      $display("FAIL bad_commit_err obs=%h expected=%h", obs, {4'd0, 4'd7, 4'd5, 2'd2, 1'b0, 1'b1}); miscompares++;
    end
    tick();
    vectors++;
    if (obs !== {4'd0, 4'd7, 4'd5, 2'd2, 1'b0, 1'b0}) begin
      $display("FAIL bad_commit_retain obs=%h expected=%h", obs, {4'd0, 4'd7, 4'd5, 2'd2, 1'b0, 1'b0}); miscompares++;
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    vectors++;
    if (obs !== 16'h0000) begin
      $display("FAIL cancel_clear obs=%h expected=%h", obs, 16'h0000); miscompares++;
    end
  endtask

  task automatic test_busy();
    busy = 1'b1;
    press(4'd4);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    vectors++;
    if ({err_first, err_second} !== 2'b00 || obs !== 16'h0000) begin
      $display("FAIL busy_ignore obs=%h err=%b expected=%h err=00", obs, {err_first, err_second}, 16'h0000); miscompares++;
    end
    busy = 1'b0;
    press(4'd12);
    vectors++;
    if ({err_first, err_second} !== 2'b10 || obs !== 16'h0000) begin
      $display("FAIL non_bcd obs=%h err=%b expected=%h err=10", obs, {err_first, err_second}, 16'h0000); miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    // Digit and commit in the same cycle: digit wins, commit dropped.
    D = 4'd2; loadn = 1'b0; commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    vectors++;
    if (obs !== {4'd0, 4'd0, 4'd2, 2'd1, 1'b0, 1'b0}) begin
      $display("FAIL digit_beats_commit obs=%h expected=%h", obs, {4'd0, 4'd0, 4'd2, 2'd1, 1'b0, 1'b0}); miscompares++;
    end
    loadn = 1'b1;
    tick();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    vectors++;
    if (obs !== {4'd0, 4'd0, 4'd2, 2'd1, 1'b1, 1'b0}) begin
      $display("FAIL commit_single obs=%h expected=%h", obs, {4'd0, 4'd0, 4'd2, 2'd1, 1'b1, 1'b0}); miscompares++;
    end
    // Asynchronous reset in the middle of a transfer.
    clearn = 1'b0;
    #2;
    vectors++;
    if (obs !== 16'h0000) begin
      $display("FAIL reset_mid_xfer obs=%h expected=%h", obs, 16'h0000); miscompares++;
    end
    xfer_ready = 1'b1;
    tick();
    clearn = 1'b1;
    tick(); tick();
    xfer_ready = 1'b0;
    vectors++;
    if (obs !== 16'h0000) begin
      $display("FAIL no_xfer_after_reset obs=%h expected=%h", obs, 16'h0000); miscompares++;
    end
  endtask

  task automatic test_cancel_priority();
    press(4'd5);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    vectors++;
    if (obs !== {4'd0, 4'd0, 4'd5, 2'd1, 1'b1, 1'b0}) begin
      $display("FAIL cancel_setup obs=%h expected=%h", obs, {4'd0, 4'd0, 4'd5, 2'd1, 1'b1, 1'b0}); miscompares++;
    end
    cancel = 1'b1; xfer_ready = 1'b1;
    tick();
    cancel = 1'b0; xfer_ready = 1'b0;
    vectors++;
    if (obs !== 16'h0000) begin
      $display("FAIL cancel_in_xfer obs=%h expected=%h", obs, 16'h0000); miscompares++;
    end
    // Cancel together with a digit: the digit is discarded.
    D = 4'd8; loadn = 1'b0; cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tick();
    loadn = 1'b1;
    tick();
    vectors++;
    if (obs !== 16'h0000) begin
      $display("FAIL cancel_beats_digit obs=%h expected=%h", obs, 16'h0000); miscompares++;
    end
    // xfer_ready outside XFER does nothing.
    xfer_ready = 1'b1;
    press(4'd6);
    xfer_ready = 1'b0;
    vectors++;
    if (obs !== {4'd0, 4'd0, 4'd6, 2'd1, 1'b0, 1'b0}) begin
      $display("FAIL ready_outside_xfer obs=%h expected=%h", obs, {4'd0, 4'd0, 4'd6, 2'd1, 1'b0, 1'b0}); miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_full_reject();
    test_xfer();
    test_bad_commit();
    test_busy();
    test_back_to_back();
    test_cancel_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
